// File: rtl/dmem_sram_responder.sv
// dmem_sram_responder: data-side memory responder with a word-wide SRAM model and programmable wait states.
// Optional completion/stall statistics are built when DMEM_STATS_EN is defined.
`default_nettype none

module dmem_sram_responder #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_en,
   input  logic [3:0]  req_wen,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_wdata,
   input  logic        cpu_stall,
   output logic [31:0] rdata,
   output logic        stall_req,
   output logic [31:0] stat_rd,
   output logic [31:0] stat_wr,
   output logic [31:0] stat_stall
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [31:0]         rdata_q;
   logic [31:0]         mem_q [0:(1<<ADDR_W)-1];
   logic [ADDR_W-1:0]   idx;
   logic                access;

   // Upper address bits alias onto the array; size is informational only.
   logic unused_sigs;
   assign unused_sigs = ^{req_size, req_addr[31:ADDR_W+2], req_addr[1:0]};

   assign idx    = req_addr[ADDR_W+1:2];
   assign access = (state_q == ST_BUSY) && req_en && (cnt_q == 4'd0);
   assign rdata  = rdata_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (access) begin
            rdata_q <= mem_q[idx];
         end
      end
   end

   // Array is never cleared; a reset edge coinciding with completion blocks the write.
   always_ff @(posedge clk) begin
      if (access && !rst) begin
         for (int i = 0; i < 4; i++) begin
            if (req_wen[i]) begin
               mem_q[idx][8*i +: 8] <= req_wdata[8*i +: 8];
            end
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stall_req = 1'b0;
      case (state_q)
         ST_IDLE: begin
            stall_req = req_en;
            if (req_en) begin
               state_d = ST_BUSY;
               cnt_d   = WAIT_INIT;
            end
         end
         ST_BUSY: begin
            stall_req = req_en;
            if (!req_en) begin
               state_d = ST_IDLE;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!cpu_stall) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

`ifdef DMEM_STATS_EN
   logic [31:0] stat_rd_q, stat_wr_q, stat_stall_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_rd_q    <= 32'h0;
         stat_wr_q    <= 32'h0;
         stat_stall_q <= 32'h0;
      end else begin
         if (access) begin
            if (|req_wen) begin
               stat_wr_q <= stat_wr_q + 32'd1;
            end else begin
               stat_rd_q <= stat_rd_q + 32'd1;
            end
         end
         if (stall_req) begin
            stat_stall_q <= stat_stall_q + 32'd1;
         end
      end
   end

   assign stat_rd    = stat_rd_q;
   assign stat_wr    = stat_wr_q;
   assign stat_stall = stat_stall_q;
`else
   assign stat_rd    = 32'h0;
   assign stat_wr    = 32'h0;
   assign stat_stall = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_sram_responder.sv
// tb_dmem_sram_responder: randomized self-checking bench against a word-array reference model.
`default_nettype none

module tb_dmem_sram_responder;

   localparam int AW = 10;
   localparam int WC = 1;
`ifdef DMEM_STATS_EN
   localparam bit STATS_ON = 1'b1;
`else
   localparam bit STATS_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_en, req_en0;
   logic [3:0]  req_wen;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic        cpu_stall;
   logic [31:0] rdata, rdata0;
   logic        stall_req, stall_req0;
   logic [31:0] stat_rd, stat_wr, stat_stall;
   logic [31:0] stat_rd0, stat_wr0, stat_stall0;

   int checks = 0;
   int failures = 0;

   // Reference model: word array plus a flag marking words whose every byte is defined.
   logic [31:0] mdl [0:(1<<AW)-1];
   bit          known [0:(1<<AW)-1];
   int          exp_rd, exp_wr, exp_stall;

   always #5 clk = ~clk;

   dmem_sram_responder #(.ADDR_W(AW), .WAIT_CYCLES(WC)) u_dut (
      .clk(clk), .rst(rst), .req_en(req_en), .req_wen(req_wen), .req_addr(req_addr),
      .req_size(req_size), .req_wdata(req_wdata), .cpu_stall(cpu_stall),
      .rdata(rdata), .stall_req(stall_req),
      .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_stall(stat_stall)
   );

   dmem_sram_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst(rst), .req_en(req_en0), .req_wen(req_wen), .req_addr(req_addr),
      .req_size(req_size), .req_wdata(req_wdata), .cpu_stall(cpu_stall),
      .rdata(rdata0), .stall_req(stall_req0),
      .stat_rd(stat_rd0), .stat_wr(stat_wr0), .stat_stall(stat_stall0)
   );

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] wen);
      logic [31:0] r = old;
      for (int i = 0; i < 4; i++) if (wen[i]) r[8*i +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   // Model update; returns the word the DUT must present (old contents).
   function automatic logic [31:0] model_apply(input logic [31:0] addr, input logic [3:0] wen,
                                              input logic [31:0] wd);
      int idx = int'(addr[AW+1:2]);
      logic [31:0] old = mdl[idx];
      mdl[idx] = merge(old, wd, wen);
      if (wen == 4'hF) known[idx] = 1'b1;
      if (wen != 4'h0) exp_wr++; else exp_rd++;
      exp_stall += WC + 2;
      return old;
   endfunction

   // Full request handshake; starts and ends at a falling edge with req_en low.
   task automatic access(input bit sel, input logic [31:0] addr, input logic [3:0] wen,
                         input logic [31:0] wd, input int hold, output logic [31:0] rd);
      int n = 0;
      int wc = sel ? 0 : WC;
      req_addr = addr; req_wen = wen; req_wdata = wd; req_size = 2'd2;
      if (sel) req_en0 = 1'b1; else req_en = 1'b1;
      #1;
      while ((sel ? stall_req0 : stall_req) === 1'b1 && n < 40) begin
         n++;
         @(negedge clk); #1;
      end
      checks++;
      if (n != wc + 2) begin
         failures++;
         $display("FAIL stall_len addr=%h: got %0d cycles expected %0d", addr, n, wc + 2);
      end
      rd = sel ? rdata0 : rdata;
      cpu_stall = 1'b1;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk); #1;
         checks++;
         if ((sel ? rdata0 : rdata) !== rd || (sel ? stall_req0 : stall_req) !== 1'b0) begin
            failures++;
            $display("FAIL done_hold: rdata=%h stall=%b expected rdata=%h stall=0",
                     sel ? rdata0 : rdata, sel ? stall_req0 : stall_req, rd);
         end
      end
      cpu_stall = 1'b0;
      @(negedge clk);
      req_en = 1'b0; req_en0 = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] rd, e;
      rst = 1'b1; req_en = 1'b0; req_en0 = 1'b0; req_wen = 4'h0; req_addr = 32'h0;
      req_wdata = 32'h0; req_size = 2'd0; cpu_stall = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (stall_req !== 1'b0 || rdata !== 32'h0 || rdata0 !== 32'h0) begin
         failures++;
         $display("FAIL reset_state: stall=%b rdata=%h rdata0=%h expected 0/0/0", stall_req, rdata, rdata0);
      end
      checks++;
      if (stat_rd !== 32'h0 || stat_wr !== 32'h0 || stat_stall !== 32'h0) begin
         failures++;
         $display("FAIL reset_stats: rd=%0d wr=%0d stall=%0d expected 0", stat_rd, stat_wr, stat_stall);
      end
      @(negedge clk);
      rst = 1'b0;
      e = model_apply(32'h20, 4'hF, 32'h11223344);
      access(1'b0, 32'h20, 4'hF, 32'h11223344, 0, rd);
      // Store aborted by reset one cycle into BUSY.
      req_addr = 32'h20; req_wen = 4'hF; req_wdata = 32'h55667788; req_en = 1'b1;
      @(negedge clk);
      rst = 1'b1; req_en = 1'b0;
      #1;
      checks++;
      if (stall_req !== 1'b0 || rdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_mid_busy: stall=%b rdata=%h expected 0/0", stall_req, rdata);
      end
      @(negedge clk);
      rst = 1'b0;
      exp_rd = 0; exp_wr = 0; exp_stall = 0;
      e = model_apply(32'h20, 4'h0, 32'h0);
      access(1'b0, 32'h20, 4'h0, 32'h0, 0, rd);
      checks++;
      if (rd !== e) begin
         failures++;
         $display("FAIL reset_no_write: got %h expected %h", rd, e);
      end
   endtask

   task automatic test_store_load();
      logic [31:0] rd, e;
      e = model_apply(32'h10, 4'hF, 32'hDEADBEEF);
      access(1'b0, 32'h10, 4'hF, 32'hDEADBEEF, 0, rd);
      e = model_apply(32'h10, 4'h0, 32'h0);
      access(1'b0, 32'h10, 4'h0, 32'h0, 0, rd);
      checks++;
      if (rd !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL store_load: got %h expected %h", rd, 32'hDEADBEEF);
      end
   endtask

   task automatic test_byte_store();
      logic [31:0] rd, e;
      e = model_apply(32'h11, 4'b0010, 32'h0000AA00);
      access(1'b0, 32'h11, 4'b0010, 32'h0000AA00, 0, rd);
      checks++;
      if (rd !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL byte_store_old: got %h expected %h", rd, 32'hDEADBEEF);
      end
      e = model_apply(32'h10, 4'h0, 32'h0);
      access(1'b0, 32'h10, 4'h0, 32'h0, 0, rd);
      checks++;
      if (rd !== 32'hDEADAAEF) begin
         failures++;
         $display("FAIL byte_store: got %h expected %h", rd, 32'hDEADAAEF);
      end
   endtask

   task automatic test_flush();
      logic [31:0] rd, e, prev;
      for (int s = 0; s < 2; s++) begin
         prev = rdata;
         req_addr = 32'h10; req_wen = (s == 0) ? 4'h0 : 4'hF; req_wdata = 32'hFFFFFFFF;
         req_en = 1'b1;
         repeat (2) @(negedge clk);
         req_en = 1'b0;
         exp_stall += 2;
         @(negedge clk); #1;
         checks++;
         if (stall_req !== 1'b0 || rdata !== prev || stat_rd !== (STATS_ON ? 32'(exp_rd) : 32'h0)
             || stat_wr !== (STATS_ON ? 32'(exp_wr) : 32'h0)) begin
            failures++;
            $display("FAIL flush%0d: stall=%b rdata=%h rd=%0d wr=%0d expected 0/%h/%0d/%0d", s,
                     stall_req, rdata, stat_rd, stat_wr, prev, exp_rd, exp_wr);
         end
      end
      e = model_apply(32'h10, 4'h0, 32'h0);
      access(1'b0, 32'h10, 4'h0, 32'h0, 0, rd);
      checks++;
      if (rd !== e) begin
         failures++;
         $display("FAIL flush_mem: got %h expected %h", rd, e);
      end
   endtask

   task automatic test_done_hold();
      logic [31:0] rd, e;
      e = model_apply(32'h10, 4'h0, 32'h0);
      access(1'b0, 32'h10, 4'h0, 32'h0, 4, rd);
      #1;
      checks++;
      if (rd !== e || stat_rd !== (STATS_ON ? 32'(exp_rd) : 32'h0)) begin
         failures++;
         $display("FAIL done_hold_single: rdata=%h rd=%0d expected %h/%0d", rd, stat_rd, e, exp_rd);
      end
   endtask

   task automatic test_alias();
      logic [31:0] rd, e;
      e = model_apply(32'h1000_0004, 4'hF, 32'hCAFEF00D);
      access(1'b0, 32'h1000_0004, 4'hF, 32'hCAFEF00D, 0, rd);
      e = model_apply(32'h0000_0004, 4'h0, 32'h0);
      access(1'b0, 32'h0000_0004, 4'h0, 32'h0, 0, rd);
      checks++;
      if (rd !== 32'hCAFEF00D) begin
         failures++;
         $display("FAIL alias: got %h expected %h", rd, 32'hCAFEF00D);
      end
      access(1'b1, 32'h1000_0004, 4'hF, 32'h0BADC0DE, 0, rd);
      access(1'b1, 32'h0000_0004, 4'h0, 32'h0, 0, rd);
      checks++;
      if (rd !== 32'h0BADC0DE) begin
         failures++;
         $display("FAIL alias_wait0: got %h expected %h", rd, 32'h0BADC0DE);
      end
   endtask

   task automatic test_random();
      logic [31:0] rd, e, addr, wd;
      logic [3:0]  wen;
      int idx;
      bit was_known;
      for (int t = 0; t < 48; t++) begin
         idx  = $urandom_range(0, 7);
         addr = ($urandom & 32'hFFFF_F000) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
         wen  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
         wd   = $urandom;
         was_known = known[idx];
         e = model_apply(addr, wen, wd);
         access(1'b0, addr, wen, wd, $urandom_range(0, 2), rd);
         if (was_known) begin
            checks++;
            if (rd !== e) begin
               failures++;
               $display("FAIL random[%0d] addr=%h wen=%h: got %h expected %h", t, addr, wen, rd, e);
            end
         end
      end
   endtask

   task automatic test_stats();
      #1;
      checks++;
      if (stat_rd !== (STATS_ON ? 32'(exp_rd) : 32'h0) || stat_wr !== (STATS_ON ? 32'(exp_wr) : 32'h0)
          || stat_stall !== (STATS_ON ? 32'(exp_stall) : 32'h0)) begin
         failures++;
         $display("FAIL stats: rd=%0d wr=%0d stall=%0d expected %0d/%0d/%0d", stat_rd, stat_wr,
                  stat_stall, STATS_ON ? exp_rd : 0, STATS_ON ? exp_wr : 0, STATS_ON ? exp_stall : 0);
      end
      checks++;
      if (stat_rd0 !== (STATS_ON ? 32'd1 : 32'h0) || stat_wr0 !== (STATS_ON ? 32'd1 : 32'h0)
          || stat_stall0 !== (STATS_ON ? 32'd4 : 32'h0)) begin
         failures++;
         $display("FAIL stats_wait0: rd=%0d wr=%0d stall=%0d", stat_rd0, stat_wr0, stat_stall0);
      end
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) begin
         mdl[i] = 32'h0;
         known[i] = 1'b0;
      end
      exp_rd = 0; exp_wr = 0; exp_stall = 0;
      test_reset();
      test_store_load();
      test_byte_store();
      test_flush();
      test_done_hold();
      test_alias();
      test_random();
      test_stats();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
